// File: rtl/dma_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : dma_pkg                                                       |
// | Description: Shared DMA definitions. Holds the control-register bit        |
// |              positions (also used by the register file), the direction     |
// |              encodings and the transfer engine state encoding.             |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package dma_pkg;

    // Control register bit positions
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_DIR_BIT = 1;

    // Direction encodings (value of ctrl bit CTRL_DIR_BIT)
    localparam logic DIR_READ  = 1'b0;   // RAM -> peripheral
    localparam logic DIR_WRITE = 1'b1;   // peripheral -> RAM

    // Transfer engine states, explicitly encoded
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_REQ    = 3'd1,
        RD_WAIT   = 3'd2,
        RD_PUSH   = 3'd3,
        WR_ACCEPT = 3'd4,
        WR_COMMIT = 3'd5,
        DONE      = 3'd6
    } dma_state_t;

endpackage
`default_nettype wire

// File: rtl/dma_transfer_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : dma_transfer_engine                                           |
// | Description: Moves words between RAM and a peripheral stream port using    |
// |              the DMA control/address/count registers. Read direction       |
// |              streams RAM words out on tx_*, write direction stores rx_*    |
// |              words into RAM. Reports busy, a done pulse and sticky abort.  |
// | Ports      : clk, reset          - clock, synchronous active-high reset    |
// |              ctrl_sig_reg        - bit0 enable, bit1 direction             |
// |              addr_reg, count_reg - start word address, word count          |
// |              mem_*               - RAM port (read data 1 cycle latency)    |
// |              tx_*                - peripheral output stream (valid/ready)  |
// |              rx_*                - peripheral input stream (valid/ready)   |
// |              busy, done, aborted - status back to the CPU side             |
// |              xfer_addr/remaining - live transfer progress                  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module dma_transfer_engine
    import dma_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ctrl_sig_reg,
    input  logic [31:0]       addr_reg,
    input  logic [31:0]       count_reg,
    output logic [31:0]       mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [31:0]       xfer_addr,
    output logic [31:0]       xfer_remaining
);

    dma_state_t        r_state;
    logic              r_en_prev;
    logic              r_dir;
    logic [DATA_W-1:0] r_buf;      // read word awaiting push, or write word awaiting commit

    dma_state_t        w_state_nxt;
    logic [31:0]       w_addr_nxt;
    logic [31:0]       w_rem_nxt;
    logic              w_dir_nxt;
    logic [DATA_W-1:0] w_buf_nxt;
    logic              w_aborted_nxt;
    logic              w_en;
    logic              w_start;
    logic              w_step;     // a word completes this cycle
    logic              w_last;
    logic              w_unused_ctrl;

    assign w_en          = ctrl_sig_reg[CTRL_EN_BIT];
    assign w_start       = (r_state == IDLE) && w_en && !r_en_prev;
    assign w_last        = (xfer_remaining <= 32'd1);
    assign w_unused_ctrl = ^ctrl_sig_reg[31:2];

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = xfer_addr;
        w_rem_nxt     = xfer_remaining;
        w_dir_nxt     = r_dir;
        w_buf_nxt     = r_buf;
        w_aborted_nxt = aborted;
        w_step        = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_addr_nxt    = addr_reg;
                    w_rem_nxt     = count_reg;
                    w_dir_nxt     = ctrl_sig_reg[CTRL_DIR_BIT];
                    w_aborted_nxt = 1'b0;
                    if (count_reg == 32'd0)
                        w_state_nxt = DONE;
                    else if (ctrl_sig_reg[CTRL_DIR_BIT] == DIR_WRITE)
                        w_state_nxt = WR_ACCEPT;
                    else
                        w_state_nxt = RD_REQ;
                end
            end
            RD_REQ:  w_state_nxt = RD_WAIT;
            RD_WAIT: begin
                w_buf_nxt   = mem_rd_data;
                w_state_nxt = RD_PUSH;
            end
            RD_PUSH: begin
                if (tx_ready) begin
                    w_step      = 1'b1;
                    w_state_nxt = w_last ? DONE : RD_REQ;
                end
            end
            WR_ACCEPT: begin
                if (rx_valid) begin
                    w_buf_nxt   = rx_data;
                    w_state_nxt = WR_COMMIT;
                end
            end
            WR_COMMIT: begin
                w_step      = 1'b1;
                w_state_nxt = w_last ? DONE : WR_ACCEPT;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        // The strobe already on the bus this cycle still counts, even on abort
        if (w_step) begin
            w_addr_nxt = xfer_addr + 32'd1;
            w_rem_nxt  = (xfer_remaining != 32'd0) ? xfer_remaining - 32'd1 : 32'd0;
        end

        // Enable dropped mid-transfer: abandon without a done pulse
        if ((r_state != IDLE) && (r_state != DONE) && !w_en) begin
            w_state_nxt   = IDLE;
            w_aborted_nxt = 1'b1;
        end
    end

    // Outputs are registered from the next-state values so each one is
    // valid during the cycle its state is active.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_en_prev      <= 1'b0;
            r_dir          <= DIR_READ;
            r_buf          <= '0;
            xfer_addr      <= '0;
            xfer_remaining <= '0;
            aborted        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_addr       <= '0;
            mem_rd_en      <= 1'b0;
            mem_wr_en      <= 1'b0;
            mem_wr_data    <= '0;
            tx_valid       <= 1'b0;
            tx_data        <= '0;
            rx_ready       <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_en_prev      <= w_en;
            r_dir          <= w_dir_nxt;
            r_buf          <= w_buf_nxt;
            xfer_addr      <= w_addr_nxt;
            xfer_remaining <= w_rem_nxt;
            aborted        <= w_aborted_nxt;
            busy           <= (w_state_nxt != IDLE) && (w_state_nxt != DONE);
            done           <= (w_state_nxt == DONE);
            mem_addr       <= w_addr_nxt;
            mem_rd_en      <= (w_state_nxt == RD_REQ);
            mem_wr_en      <= (w_state_nxt == WR_COMMIT);
            mem_wr_data    <= w_buf_nxt;
            tx_valid       <= (w_state_nxt == RD_PUSH);
            tx_data        <= w_buf_nxt;
            rx_ready       <= (w_state_nxt == WR_ACCEPT);
        end
    end

endmodule
`default_nettype wire
